// File: rtl/pipe_flow_pkg.sv
// Shared types and helpers for the pipeline flow controller.
// The popcount helper is used by the checker; sat_inc is used by the perf counters.
package pipe_flow_pkg;

  localparam int MAX_DEPTH = 32;

  typedef logic [31:0] perf_cnt_t;

  function automatic logic [5:0] popcount(input logic [MAX_DEPTH-1:0] vec);
    logic [5:0] cnt;
    cnt = 6'd0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      cnt = cnt + {5'd0, vec[i]};
    end
    return cnt;
  endfunction

  function automatic perf_cnt_t sat_inc(input perf_cnt_t cnt, input logic ev);
    if (ev && (cnt != 32'hFFFF_FFFF)) begin
      return cnt + 32'd1;
    end else begin
      return cnt;
    end
  endfunction

endpackage

// File: rtl/pipe_flow_ctrl_chk.sv
// Property checker for pipe_flow_ctrl: occupancy consistency, valid-bit retention
// and all-enabled while empty. Contains assertions only, no functional logic.
module pipe_flow_ctrl_chk
  import pipe_flow_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input logic             clk,
  input logic             rst,
  input logic             flush,
  input logic             out_ready,
  input logic [DEPTH-1:0] stage_en,
  input logic [DEPTH-1:0] stage_valid,
  input logic [CNT_W-1:0] occupancy
);

  logic [DEPTH-1:0] moved_s;

  a_occ_popcount: assert property (@(posedge clk) disable iff (rst)
    popcount(MAX_DEPTH'(stage_valid)) == 6'(occupancy));

  a_empty_all_en: assert property (@(posedge clk) disable iff (rst)
    (occupancy == {CNT_W{1'b0}}) |-> (&stage_en));

  // A valid item may only leave its stage by moving downstream.
  for (genvar i = 0; i < DEPTH; i++) begin : g_hold
    if (i == DEPTH - 1) begin : g_last
      assign moved_s[i] = out_ready;
    end else begin : g_mid
      assign moved_s[i] = stage_en[i+1];
    end
    a_hold: assert property (@(posedge clk)
      (!rst && !flush && stage_valid[i] && !moved_s[i]) |=> stage_valid[i]);
  end

endmodule

// File: rtl/pipe_flow_perf.sv
// Saturating stall / starve / transfer counters for pipe_flow_ctrl.
// Cleared by rst only; flush leaves them untouched.
module pipe_flow_perf
  import pipe_flow_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      stall_ev,
  input  logic      starve_ev,
  input  logic      xfer_ev,
  output perf_cnt_t stall_cnt,
  output perf_cnt_t starve_cnt,
  output perf_cnt_t xfer_cnt
);

  perf_cnt_t stall_r;
  perf_cnt_t starve_r;
  perf_cnt_t xfer_r;

  // Counter registers with saturation at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_r  <= 32'd0;
      starve_r <= 32'd0;
      xfer_r   <= 32'd0;
    end else begin
      stall_r  <= sat_inc(stall_r, stall_ev);
      starve_r <= sat_inc(starve_r, starve_ev);
      xfer_r   <= sat_inc(xfer_r, xfer_ev);
    end
  end

  assign stall_cnt  = stall_r;
  assign starve_cnt = starve_r;
  assign xfer_cnt   = xfer_r;

endmodule

// File: rtl/pipe_flow_ctrl.sv
// Valid/enable controller for a DEPTH-stage bubble-collapsing pipeline.
// Define PIPE_FLOW_CTRL_PERF_EN to add stall/starve/transfer counters.
module pipe_flow_ctrl
  import pipe_flow_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             flush,
  output logic [DEPTH-1:0] stage_en,
  output logic [DEPTH-1:0] stage_valid,
  output logic [CNT_W-1:0] occupancy,
  output logic             idle
`ifdef PIPE_FLOW_CTRL_PERF_EN
  ,
  output perf_cnt_t        stall_cnt,
  output perf_cnt_t        starve_cnt,
  output perf_cnt_t        xfer_cnt
`endif
);

  logic [DEPTH-1:0] valid_r;
  logic [DEPTH-1:0] valid_nxt_s;
  logic [DEPTH-1:0] en_s;
  logic [CNT_W-1:0] occ_r;
  logic [CNT_W-1:0] occ_nxt_s;
  logic             idle_r;
  logic             up_xfer_s;
  logic             dn_xfer_s;

  // Enable chain from the output back: a stage loads if it is empty or its item moves on.
  always_comb begin
    logic chain_s;
    en_s    = {DEPTH{1'b0}};
    chain_s = !valid_r[DEPTH-1] | out_ready;
    en_s[DEPTH-1] = chain_s;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      chain_s = !valid_r[i] | chain_s;
      en_s[i] = chain_s;
    end
  end

  // Next valid bits: enabled stages take the valid bit of their upstream neighbour.
  always_comb begin
    valid_nxt_s = valid_r;
    if (en_s[0]) begin
      valid_nxt_s[0] = in_valid;
    end else begin
      valid_nxt_s[0] = valid_r[0];
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (en_s[i]) begin
        valid_nxt_s[i] = valid_r[i-1];
      end else begin
        valid_nxt_s[i] = valid_r[i];
      end
    end
  end

  assign up_xfer_s = in_valid & en_s[0];
  assign dn_xfer_s = valid_r[DEPTH-1] & out_ready;
  assign occ_nxt_s = occ_r + CNT_W'(up_xfer_s) - CNT_W'(dn_xfer_s);

  // State registers; flush discards everything in flight, including this cycle's input.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_r <= {DEPTH{1'b0}};
      occ_r   <= {CNT_W{1'b0}};
      idle_r  <= 1'b1;
    end else begin
      valid_r <= valid_nxt_s;
      occ_r   <= occ_nxt_s;
      idle_r  <= (occ_nxt_s == {CNT_W{1'b0}});
    end
  end

  assign stage_en    = en_s;
  assign stage_valid = valid_r;
  assign in_ready    = en_s[0];
  assign out_valid   = valid_r[DEPTH-1];
  assign occupancy   = occ_r;
  assign idle        = idle_r;

  pipe_flow_ctrl_chk #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_chk (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .out_ready   (out_ready),
    .stage_en    (en_s),
    .stage_valid (valid_r),
    .occupancy   (occ_r)
  );

`ifdef PIPE_FLOW_CTRL_PERF_EN
  pipe_flow_perf u_perf (
    .clk        (clk),
    .rst        (rst),
    .stall_ev   (valid_r[DEPTH-1] & !out_ready),
    .starve_ev  (!in_valid & en_s[0]),
    .xfer_ev    (dn_xfer_s),
    .stall_cnt  (stall_cnt),
    .starve_cnt (starve_cnt),
    .xfer_cnt   (xfer_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Scoreboard bench for pipe_flow_ctrl: an item/position model predicts control outputs,
// and a shadow datapath driven by stage_en carries item ids checked in order at the output.
module tb_pipe_flow_ctrl;
  import pipe_flow_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic             flush;
  logic [DEPTH-1:0] stage_en;
  logic [DEPTH-1:0] stage_valid;
  logic [CNT_W-1:0] occupancy;
  logic             idle;
  logic [15:0]      in_data;
`ifdef PIPE_FLOW_CTRL_PERF_EN
  perf_cnt_t        stall_cnt;
  perf_cnt_t        starve_cnt;
  perf_cnt_t        xfer_cnt;
  logic [31:0]      m_stall;
  logic [31:0]      m_starve;
  logic [31:0]      m_xfer;
`endif

  pipe_flow_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .flush       (flush),
    .stage_en    (stage_en),
    .stage_valid (stage_valid),
    .occupancy   (occupancy),
    .idle        (idle)
`ifdef PIPE_FLOW_CTRL_PERF_EN
    ,
    .stall_cnt   (stall_cnt),
    .starve_cnt  (starve_cnt),
    .xfer_cnt    (xfer_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int id;
    int pos;
  } item_t;

  item_t       pipe_q[$];
  int          exp_q[$];
  int          tests;
  int          fails;
  int          next_id;
  bit          started;
  logic [15:0] data_r [DEPTH];

  // Shadow datapath: plain data registers loaded by the controller's enables.
  always @(posedge clk) begin
    if (stage_en[0]) data_r[0] <= in_data;
    for (int i = 1; i < DEPTH; i++) begin
      if (stage_en[i]) data_r[i] <= data_r[i-1];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Output monitor: every downstream transfer must deliver the next expected item.
  always @(negedge clk) begin
    if (started && out_valid && out_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL out_unexpected: got item %0h, want no transfer (t=%0t)", data_r[DEPTH-1], $time);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (data_r[DEPTH-1] !== e[15:0]) begin
          fails++;
          $display("FAIL out_data: got %0h, want %0h (t=%0t)", data_r[DEPTH-1], e[15:0], $time);
        end
      end
    end
  end

  // One clock cycle: drive, predict from the item model, check, advance the model.
  task automatic cycle(input bit iv, input bit ordy, input bit fl, input bit rs);
    int               n;
    int               barrier;
    int               first;
    bit               dlv;
    bit               rdy_e;
    bit               ov_e;
    logic [DEPTH-1:0] sv_e;
    logic [DEPTH-1:0] en_e;
    int               newpos[$];
    item_t            nq[$];
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    rst       = rs;
    in_data   = next_id[15:0];
    n     = pipe_q.size();
    ov_e  = (n > 0) && (pipe_q[0].pos == DEPTH - 1);
    dlv   = ov_e && ordy;
    first = dlv ? 1 : 0;
    sv_e  = '0;
    en_e  = '1;
    for (int k = 0; k < n; k++) sv_e[pipe_q[k].pos] = 1'b1;
    barrier = DEPTH;
    for (int k = first; k < n; k++) begin
      int p;
      p = (pipe_q[k].pos + 1 < barrier) ? pipe_q[k].pos + 1 : pipe_q[k].pos;
      if (p == pipe_q[k].pos) en_e[p] = 1'b0;
      newpos.push_back(p);
      barrier = p;
    end
    rdy_e = (barrier > 0);
    if (dlv) exp_q.push_back(pipe_q[0].id);
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(rdy_e));
    chk("out_valid", 32'(out_valid), 32'(ov_e));
    chk("stage_valid", 32'(stage_valid), 32'(sv_e));
    chk("stage_en", 32'(stage_en), 32'(en_e));
    chk("occupancy", 32'(occupancy), 32'(n));
    chk("idle", 32'(idle), 32'(n == 0));
`ifdef PIPE_FLOW_CTRL_PERF_EN
    chk("stall_cnt", stall_cnt, m_stall);
    chk("starve_cnt", starve_cnt, m_starve);
    chk("xfer_cnt", xfer_cnt, m_xfer);
    if (rs) begin
      m_stall = 0; m_starve = 0; m_xfer = 0;
    end else begin
      if (ov_e && !ordy) m_stall++;
      if (!iv && rdy_e) m_starve++;
      if (dlv) m_xfer++;
    end
`endif
    for (int k = first; k < n; k++) nq.push_back('{id: pipe_q[k].id, pos: newpos[k-first]});
    if (iv && rdy_e) begin
      nq.push_back('{id: next_id, pos: 0});
      next_id++;
    end
    if (fl || rs) nq.delete();
    pipe_q = nq;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0; fails = 0; next_id = 1; started = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_data = 16'd0;
`ifdef PIPE_FLOW_CTRL_PERF_EN
    m_stall = 0; m_starve = 0; m_xfer = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    started = 1;
    // Reset state, then streaming at full rate.
    for (int i = 0; i < 10; i++) cycle(1, 1, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0);
    // Backpressure: fill, release for one cycle, hold again, drain.
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0);
    // Bubble collapse with downstream stalled, then refill.
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
    // Flush a full pipe with a simultaneous input.
    cycle(1, 0, 1, 0);
    for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0);
    // Flush with a simultaneous downstream transfer.
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0);
    cycle(1, 1, 1, 0);
    cycle(0, 1, 0, 0);
    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 500; i++) begin
      cycle($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 55,
            $urandom_range(0, 99) < 3, $urandom_range(0, 199) == 0);
    end
    for (int i = 0; i < DEPTH + 4; i++) cycle(0, 1, 0, 0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
